// File: rtl/ddr_in_pkg.sv
// Shared definitions for the multi-lane DDR input deserializer:
// default parameters, word/slice helpers and parameter legality checks.
package ddr_in_pkg;

  localparam int DEF_LANES      = 2;
  localparam int DEF_DESER      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int PAIRS = DEF_DESER / 2;
  localparam int CNT_W = $clog2(PAIRS);

  function automatic int pairs_of(input int deser);
    return deser / 2;
  endfunction

  function automatic int cnt_w_of(input int deser);
    return (deser / 2 > 1) ? $clog2(deser / 2) : 1;
  endfunction

  // LSB index of lane l inside a packed multi-lane word.
  function automatic int lane_word(input int l, input int deser);
    return l * deser;
  endfunction

  function automatic bit deser_ok(input int deser);
    return (deser % 2 == 0) && (deser >= 4) && (deser <= 16);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit lanes_ok(input int lanes);
    return (lanes >= 1) && (lanes <= 8);
  endfunction

endpackage

// File: rtl/ddr_in_deser_fifo.sv
// Synchronous FIFO with registered storage and combinational head output.
// Handshake: a pop happens when pop_i is high and the FIFO is not empty; a
// push is accepted when not full, or when full and a pop happens on the same edge.
module ddr_in_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok, push_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Storage is reset too so the head reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ddr_in_deser.sv
// Multi-lane DDR input deserializer: packs per-lane {neg,pos} pairs into
// DESER-bit words, supports bitslip word alignment and buffers words in a FIFO.
module ddr_in_deser
  import ddr_in_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DESER      = DEF_DESER,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [2*LANES-1:0]            ddr_data_i,
  input  logic                          bitslip_i,
  output logic [LANES*DESER-1:0]        data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int NPAIRS = pairs_of(DESER);
  localparam int NCNT_W = cnt_w_of(DESER);
  localparam int WW     = LANES * DESER;

  if (!deser_ok(DESER)) begin : g_bad_deser
    $error("ddr_in_deser: DESER must be even and within 4..16");
  end
  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("ddr_in_deser: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("ddr_in_deser: LANES must be within 1..8");
  end

  logic [NCNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]     sr_q, sr_d;
  logic              overflow_q, overflow_d;
  logic              shift_en, last_pair, push, pop, fifo_full, fifo_empty;

  // A bitslip cycle drops the presented pair, moving the boundary one pair later.
  assign shift_en  = enable && !bitslip_i;
  assign last_pair = (cnt_q == NCNT_W'(NPAIRS - 1));
  assign push      = shift_en && last_pair;
  assign pop       = valid_o && ready_i;

  // New pairs enter at the top so the oldest pair ends up in bits [1:0].
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int LSB = lane_word(l, DESER);
    assign sr_d[LSB +: DESER] = {ddr_data_i[2*l +: 2], sr_q[LSB + 2 +: DESER - 2]};
  end

  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (shift_en) cnt_d = last_pair ? '0 : cnt_q + NCNT_W'(1);
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      if (shift_en) sr_q <= sr_d;
    end
  end

  ddr_in_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (ready_i),
    .wdata_i (sr_d),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign valid_o    = !fifo_empty;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ddr_in_deser.sv
// Bench for ddr_in_deser (LANES=2, DESER=4, FIFO_DEPTH=4): table vectors,
// directed corner sequences and random traffic against a queue-based model.
module tb_ddr_in_deser;

  localparam int LANES = 2;
  localparam int DESER = 4;
  localparam int FD    = 4;
  localparam int PAIRS = DESER / 2;
  localparam int DW    = LANES * DESER;
  localparam int PW    = 2 * LANES;
  localparam int LW    = $clog2(FD) + 1;

  logic          clk_i = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] ddr_data_i = '0;
  logic          bitslip_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [LW-1:0] level_o;
  logic          overflow_o;

  ddr_in_deser #(.LANES(LANES), .DESER(DESER), .FIFO_DEPTH(FD)) dut (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .enable     (enable),
    .ddr_data_i (ddr_data_i),
    .bitslip_i  (bitslip_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: accepted pairs of the word in progress, and queued words.
  logic [PW-1:0] acc_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  int            n_chk = 0;
  int            n_fail = 0;

  typedef struct {
    logic          en;
    logic          slip;
    logic [PW-1:0] ddr;
    logic          rdy;
    logic          ev;
    logic [LW-1:0] elvl;
    logic [DW-1:0] edata;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    acc_q.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0; bitslip_i = 1'b0; ddr_data_i = '0; ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs, check the head before the edge, update model, check state after.
  task automatic cycle(input logic en, input logic slip, input logic [PW-1:0] ddr, input logic rdy);
    logic          do_pop, was_full;
    logic [DW-1:0] w;
    enable = en; bitslip_i = slip; ddr_data_i = ddr; ready_i = rdy;
    #1;
    chk("valid_pre", 32'(valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head_data", 32'(data_o), 32'(exp_q[0]));
    @(posedge clk_i);
    was_full = (exp_q.size() == FD);
    do_pop   = rdy && (exp_q.size() != 0);
    if (do_pop) void'(exp_q.pop_front());
    if (en && !slip) begin
      acc_q.push_back(ddr);
      if (acc_q.size() == PAIRS) begin
        w = '0;
        for (int l = 0; l < LANES; l++)
          for (int k = 0; k < PAIRS; k++)
            w[l*DESER + 2*k +: 2] = acc_q[k][2*l +: 2];
        acc_q.delete();
        if (!was_full || do_pop) exp_q.push_back(w);
        else exp_ovf = 1'b1;
      end
    end
    #1;
    chk("level", 32'(level_o), 32'(exp_q.size()));
    chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow_o), 32'(exp_ovf));
  endtask

  initial begin
    model_clear();
    // Basic pack: lane0 (0,1),(1,1); lane1 (1,0),(0,0) -> 8'h1E, popped next edge.
    tbl[0] = '{en:1'b1, slip:1'b0, ddr:4'b0110, rdy:1'b1, ev:1'b0, elvl:3'd0, edata:8'h00};
    tbl[1] = '{en:1'b1, slip:1'b0, ddr:4'b0011, rdy:1'b1, ev:1'b1, elvl:3'd1, edata:8'h1E};
    tbl[2] = '{en:1'b0, slip:1'b0, ddr:4'b0000, rdy:1'b1, ev:1'b0, elvl:3'd0, edata:8'h00};

    reset_n = 1'b0;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    do_reset();

    for (int i = 0; i < 3; i++) begin
      cycle(tbl[i].en, tbl[i].slip, tbl[i].ddr, tbl[i].rdy);
      chk("tbl_valid", 32'(valid_o), 32'(tbl[i].ev));
      chk("tbl_level", 32'(level_o), 32'(tbl[i].elvl));
      if (tbl[i].ev) chk("tbl_data", 32'(data_o), 32'(tbl[i].edata));
    end

    // Bitslip on the first pair of lane0 stream 2,3,1,0,2,...: words 4'h7 then 4'h8.
    do_reset();
    cycle(1'b1, 1'b1, 4'h2, 1'b1);
    cycle(1'b1, 1'b0, 4'h3, 1'b1);
    cycle(1'b1, 1'b0, 4'h1, 1'b1);
    chk("slip_word1", 32'(data_o), 32'h07);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h2, 1'b1);
    chk("slip_word2", 32'(data_o), 32'h08);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // Enable gap with a bitslip inside it: word uses only the two enabled pairs.
    do_reset();
    cycle(1'b1, 1'b0, 4'b1001, 1'b0);
    cycle(1'b0, 1'b0, 4'hF, 1'b0);
    cycle(1'b0, 1'b1, 4'h5, 1'b0);
    cycle(1'b0, 1'b0, 4'hA, 1'b0);
    cycle(1'b1, 1'b0, 4'b0110, 1'b0);
    chk("gap_word", 32'(data_o), 32'h69);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // Backpressure: five words with ready low, fifth dropped; then drain.
    do_reset();
    for (int i = 0; i < 5 * PAIRS; i++) begin
      cycle(1'b1, 1'b0, PW'($urandom_range(0, 15)), 1'b0);
      if (i == 4 * PAIRS - 1) chk("bp_level4", 32'(level_o), 32'd4);
    end
    chk("bp_ovf", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0, 1'b1);
    chk("bp_drained", 32'(level_o), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO: push and pop on the same edge is not an overflow.
    do_reset();
    for (int i = 0; i < 4 * PAIRS; i++) cycle(1'b1, 1'b0, PW'($urandom_range(0, 15)), 1'b0);
    cycle(1'b1, 1'b0, 4'h5, 1'b0);
    cycle(1'b1, 1'b0, 4'hC, 1'b1);
    chk("full_pp_level", 32'(level_o), 32'd4);
    chk("full_pp_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0, 1'b1);

    // Asynchronous reset mid-word with two entries queued.
    do_reset();
    for (int i = 0; i < 2 * PAIRS + 1; i++) cycle(1'b1, 1'b0, PW'($urandom_range(0, 15)), 1'b0);
    chk("pre_rst_level", 32'(level_o), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_ovf", 32'(overflow_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
    model_clear();
    cycle(1'b1, 1'b0, 4'b1001, 1'b0);
    cycle(1'b1, 1'b0, 4'b0110, 1'b0);
    chk("post_rst_word", 32'(data_o), 32'h69);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 15) == 0),
            PW'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
